// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, round counts per key size and the
// round-controller FSM state encoding.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;

    localparam int AES128_NR = 10;
    localparam int AES192_NR = 12;
    localparam int AES256_NR = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/add_round_key.sv
// AddRoundKey stage: bitwise XOR of the AES state with the selected round key.
module add_round_key
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] state,
    input  logic [AES_BLOCK_W-1:0] round_key,
    output logic [AES_BLOCK_W-1:0] result
);

    assign result = state ^ round_key;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption sequencer: owns the state register and round counter
// and steps one block through NR rounds of an external combinational datapath.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR     = AES128_NR,
    parameter int KIDX_W = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clear,
    input  logic                   i_valid,
    input  logic [AES_BLOCK_W-1:0] i_data,
    output logic                   o_ready,
    output logic                   o_valid,
    output logic [AES_BLOCK_W-1:0] o_data,
    input  logic                   i_ready,
    output logic [KIDX_W-1:0]      o_key_idx,
    input  logic [AES_BLOCK_W-1:0] i_round_key,
    output logic [AES_BLOCK_W-1:0] o_round_state,
    output logic                   o_final,
    input  logic [AES_BLOCK_W-1:0] i_round_out,
    output logic                   o_busy
);

    localparam logic [KIDX_W-1:0] RND_ZERO  = {KIDX_W{1'b0}};
    localparam logic [KIDX_W-1:0] RND_ONE   = KIDX_W'(1);
    localparam logic [KIDX_W-1:0] RND_LAST  = KIDX_W'(NR - 1);
    localparam logic [KIDX_W-1:0] RND_FINAL = KIDX_W'(NR);

    ctrl_state_e            state_r;
    ctrl_state_e            state_next_s;
    logic [KIDX_W-1:0]      rnd_r;
    logic [KIDX_W-1:0]      rnd_next_s;
    logic [KIDX_W-1:0]      key_idx_r;
    logic [KIDX_W-1:0]      key_idx_next_s;
    logic [AES_BLOCK_W-1:0] data_r;
    logic [AES_BLOCK_W-1:0] data_next_s;
    logic [AES_BLOCK_W-1:0] ark_in_s;
    logic [AES_BLOCK_W-1:0] ark_out_s;
    logic                   ready_r;
    logic                   valid_r;
    logic                   busy_r;
    logic                   final_r;

    // Round 0 XORs the plaintext; every later round XORs the datapath result.
    add_round_key u_add_round_key (
        .state     (ark_in_s),
        .round_key (i_round_key),
        .result    (ark_out_s)
    );

    // Next-state, round counter and state register update; flush wins over all.
    always_comb begin
        state_next_s = state_r;
        rnd_next_s   = rnd_r;
        data_next_s  = data_r;
        ark_in_s     = i_round_out;
        if (i_clear) begin
            state_next_s = ST_IDLE;
            rnd_next_s   = RND_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ark_in_s = i_data;
                    if (i_valid && ready_r) begin
                        data_next_s  = ark_out_s;
                        rnd_next_s   = RND_ONE;
                        state_next_s = ST_ROUND;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_ROUND: begin
                    data_next_s = ark_out_s;
                    rnd_next_s  = rnd_r + RND_ONE;
                    if (rnd_r == RND_LAST) begin
                        state_next_s = ST_FINAL;
                    end else begin
                        state_next_s = ST_ROUND;
                    end
                end
                ST_FINAL: begin
                    data_next_s  = ark_out_s;
                    state_next_s = ST_DONE;
                end
                ST_DONE: begin
                    if (i_ready) begin
                        state_next_s = ST_IDLE;
                        rnd_next_s   = RND_ZERO;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    rnd_next_s   = RND_ZERO;
                end
            endcase
        end
    end

    // Key index for the upcoming cycle, so the key-store address is a flop output.
    always_comb begin
        key_idx_next_s = RND_ZERO;
        case (state_next_s)
            ST_IDLE:  key_idx_next_s = RND_ZERO;
            ST_ROUND: key_idx_next_s = rnd_next_s;
            ST_FINAL: key_idx_next_s = RND_FINAL;
            ST_DONE:  key_idx_next_s = RND_ZERO;
            default:  key_idx_next_s = RND_ZERO;
        endcase
    end

    // FSM state, round counter and AES state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            rnd_r   <= RND_ZERO;
            data_r  <= {AES_BLOCK_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            rnd_r   <= rnd_next_s;
            data_r  <= data_next_s;
        end
    end

    // Control outputs registered from the next state; never a path from i_valid.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ready_r   <= 1'b1;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            final_r   <= 1'b0;
            key_idx_r <= RND_ZERO;
        end else begin
            ready_r   <= (state_next_s == ST_IDLE);
            valid_r   <= (state_next_s == ST_DONE);
            busy_r    <= (state_next_s != ST_IDLE);
            final_r   <= (state_next_s == ST_FINAL);
            key_idx_r <= key_idx_next_s;
        end
    end

    assign o_ready       = ready_r;
    assign o_valid       = valid_r;
    assign o_busy        = busy_r;
    assign o_final       = final_r;
    assign o_key_idx     = key_idx_r;
    assign o_data        = data_r;
    assign o_round_state = data_r;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: NR=10 and NR=14 instances driven against
// a behavioural AES model (round datapath, key schedule, full encryption).
module tb_aes_round_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   clr, ivld, ordy, ovld, irdy, busy, fin;
    logic [127:0] din [2];
    logic [127:0] dout [2];
    logic [127:0] rkey [2];
    logic [127:0] rstate [2];
    logic [127:0] rout [2];
    logic [3:0]   kidx [2];
    logic [127:0] rk [2][16];
    int           cyc = 0;
    int           n_chk = 0;
    int           n_pass = 0;
    logic [1:0]   pv;
    logic [127:0] pd [2];

    typedef struct {
        logic [127:0] data;
        int           acc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_round_ctrl #(.NR(10), .KIDX_W(4)) dut10 (
        .i_clk(clk), .i_rst(rst), .i_clear(clr[0]), .i_valid(ivld[0]), .i_data(din[0]),
        .o_ready(ordy[0]), .o_valid(ovld[0]), .o_data(dout[0]), .i_ready(irdy[0]),
        .o_key_idx(kidx[0]), .i_round_key(rkey[0]), .o_round_state(rstate[0]),
        .o_final(fin[0]), .i_round_out(rout[0]), .o_busy(busy[0])
    );

    aes_round_ctrl #(.NR(14), .KIDX_W(4)) dut14 (
        .i_clk(clk), .i_rst(rst), .i_clear(clr[1]), .i_valid(ivld[1]), .i_data(din[1]),
        .o_ready(ordy[1]), .o_valid(ovld[1]), .o_data(dout[1]), .i_ready(irdy[1]),
        .o_key_idx(kidx[1]), .i_round_key(rkey[1]), .o_round_state(rstate[1]),
        .o_final(fin[1]), .i_round_out(rout[1]), .o_busy(busy[1])
    );

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (a^254) then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0]  r, e;
        logic [15:0] d;
        logic [7:0]  s;
        r = 8'h01; e = 8'hfe;
        for (int i = 7; i >= 0; i--) begin
            r = gmul(r, r);
            if (e[i]) r = gmul(r, a);
        end
        s = r ^ 8'h63;
        for (int n = 1; n <= 4; n++) begin
            d = {r, r} << n;
            s = s ^ d[15:8];
        end
        return s;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r+4*c] = b[r+4*((c+r)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o;
    endfunction

    task automatic load_key(input int sel, input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
                rc  = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r <= nr; r++) rk[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input int sel, input int nr);
        logic [127:0] s;
        s = pt ^ rk[sel][0];
        for (int r = 1; r < nr; r++) s = aes_round(s, 1'b0) ^ rk[sel][r];
        return aes_round(s, 1'b1) ^ rk[sel][nr];
    endfunction

    function automatic logic [127:0] r128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Golden external round datapath and key store
    assign rout[0] = aes_round(rstate[0], fin[0]);
    assign rout[1] = aes_round(rstate[1], fin[1]);
    assign rkey[0] = rk[0][kidx[0]];
    assign rkey[1] = rk[1][kidx[1]];

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        $display("FAIL %s: got timeout, expected event within cycle budget", name);
    endtask

    task automatic mon(input int s);
        exp_t e;
        if (ovld[s]) begin
            chk("ready_low_while_valid", {127'd0, ordy[s]}, 128'd0);
            if (!pv[s]) begin
                if (sb.size() == 0) begin
                    timeout_fail("unexpected_valid");
                end else begin
                    e = sb.pop_front();
                    chk("ciphertext", dout[s], e.data);
                    chk("latency", 128'(cyc - e.acc), (s == 0) ? 128'd10 : 128'd14);
                end
            end else begin
                chk("hold_stable", dout[s], pd[s]);
            end
        end
        pv[s] = ovld[s] && !irdy[s];
        pd[s] = dout[s];
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents a ciphertext
    always @(negedge clk) begin
        if (rst) begin
            pv = 2'b00;
        end else begin
            mon(0);
            mon(1);
        end
    end

    task automatic issue(input int sel, input logic [127:0] pt, input bit push,
                         input logic [127:0] exp, output int acc);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        ivld[sel] = 1'b1;
        din[sel]  = pt;
        while (!ordy[sel] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ordy[sel]) begin
            timeout_fail("issue_accept");
            acc = -1;
        end else begin
            acc = cyc + 1;
            if (push) begin
                e.data = exp;
                e.acc  = acc;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        ivld[sel] = 1'b0;
    endtask

    task automatic drain(input int sel, input bit rnd_rdy);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(posedge clk);
            #1;
            if (rnd_rdy) irdy[sel] = 1'($urandom_range(0, 1));
            if (sb.size() == 0 && !busy[sel]) done = 1'b1;
        end
        if (!done) timeout_fail("drain");
        irdy[sel] = 1'b1;
    endtask

    task automatic chk_reset_vals(input int s);
        chk("rst_ready", {127'd0, ordy[s]}, 128'd1);
        chk("rst_valid", {127'd0, ovld[s]}, 128'd0);
        chk("rst_busy", {127'd0, busy[s]}, 128'd0);
        chk("rst_final", {127'd0, fin[s]}, 128'd0);
        chk("rst_key_idx", {124'd0, kidx[s]}, 128'd0);
        chk("rst_data", dout[s], 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1, "watchdog expired");
    end

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    initial begin
        int           acc, acc_prev, n;
        logic [127:0] pt;
        rst = 1'b1; clr = 2'b00; ivld = 2'b00; irdy = 2'b11;
        din[0] = 128'd0; din[1] = 128'd0;
        pv = 2'b00;
        load_key(0, {KEY_B, 128'd0}, 4, 10);
        load_key(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
        #3;
        chk_reset_vals(0);
        chk_reset_vals(1);
        @(negedge clk);
        rst = 1'b0;

        // App. B with key-index trace and ignored i_valid pulses during ROUND
        issue(0, PT_B, 1'b1, CT_B, acc);
        chk("t0_state", rstate[0], 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 3) begin ivld[0] = 1'b1; din[0] = r128(); end
            if (k == 6) ivld[0] = 1'b0;
            if (k <= 10) begin
                chk("key_idx", {124'd0, kidx[0]}, 128'(k));
                chk("final_flag", {127'd0, fin[0]}, {127'd0, k == 10});
            end else begin
                chk("final_after", {127'd0, fin[0]}, 128'd0);
            end
        end
        @(posedge clk); #1;
        chk("idle_ready", {127'd0, ordy[0]}, 128'd1);
        chk("idle_busy", {127'd0, busy[0]}, 128'd0);

        // Clear beats IDLE acceptance; state register keeps the last ciphertext
        @(negedge clk);
        ivld[0] = 1'b1; din[0] = r128(); clr[0] = 1'b1;
        @(posedge clk); #1;
        ivld[0] = 1'b0; clr[0] = 1'b0;
        chk("clear_vs_accept_busy", {127'd0, busy[0]}, 128'd0);
        chk("clear_keeps_state", rstate[0], CT_B);

        // C.1 with consumer back-pressure for 5 cycles
        load_key(0, {128'h000102030405060708090a0b0c0d0e0f, 128'd0}, 4, 10);
        irdy[0] = 1'b0;
        issue(0, 128'h00112233445566778899aabbccddeeff, 1'b1,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, acc);
        n = 0;
        while (!ovld[0] && n < 50) begin @(negedge clk); n++; end
        if (!ovld[0]) timeout_fail("c1_valid");
        repeat (5) @(posedge clk);
        #1 irdy[0] = 1'b1;
        @(negedge clk);
        chk("ready_low_with_iready", {127'd0, ordy[0]}, 128'd0);
        @(posedge clk); #1;
        chk("ready_after_accept", {127'd0, ordy[0]}, 128'd1);
        chk("valid_after_accept", {127'd0, ovld[0]}, 128'd0);

        // i_clear at round 5 discards the block; then App. B again
        load_key(0, {KEY_B, 128'd0}, 4, 10);
        issue(0, PT_B, 1'b0, 128'd0, acc);
        repeat (4) @(posedge clk);
        #1;
        chk("round5_key_idx", {124'd0, kidx[0]}, 128'd5);
        clr[0] = 1'b1;
        @(posedge clk); #1;
        clr[0] = 1'b0;
        chk("clear_ready", {127'd0, ordy[0]}, 128'd1);
        chk("clear_busy", {127'd0, busy[0]}, 128'd0);
        chk("clear_key_idx", {124'd0, kidx[0]}, 128'd0);
        repeat (15) @(posedge clk);
        issue(0, PT_B, 1'b1, CT_B, acc);
        drain(0, 1'b0);

        // Async reset between edges during FINAL, then back-to-back blocks
        issue(0, r128(), 1'b0, 128'd0, acc);
        n = 0;
        while (!fin[0] && n < 40) begin @(negedge clk); n++; end
        if (!fin[0]) timeout_fail("reach_final");
        #2 rst = 1'b1;
        #1 chk_reset_vals(0);
        @(negedge clk);
        rst = 1'b0;
        load_key(0, {r128(), 128'd0}, 4, 10);
        acc_prev = 0;
        for (int b = 0; b < 4; b++) begin
            pt = r128();
            issue(0, pt, 1'b1, ref_encrypt(pt, 0, 10), acc);
            if (b > 0) chk("issue_interval", 128'(acc - acc_prev), 128'd12);
            acc_prev = acc;
        end
        drain(0, 1'b0);

        // Random keys and plaintexts with random consumer back-pressure
        for (int b = 0; b < 4; b++) begin
            load_key(0, {r128(), 128'd0}, 4, 10);
            pt = r128();
            issue(0, pt, 1'b1, ref_encrypt(pt, 0, 10), acc);
            drain(0, 1'b1);
        end

        // NR = 14 instance: C.3 vector, then random AES-256 blocks
        issue(1, 128'h00112233445566778899aabbccddeeff, 1'b1,
              128'h8ea2b7ca516745bfeafc49904b496089, acc);
        drain(1, 1'b0);
        for (int b = 0; b < 2; b++) begin
            load_key(1, {r128(), r128()}, 8, 14);
            pt = r128();
            issue(1, pt, 1'b1, ref_encrypt(pt, 1, 14), acc);
            drain(1, 1'b1);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
